fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Sequences the instruction-fetch stage against a variable-latency instruction memory using a req/ack handshake. Owns the program counter and selects the next PC: sequential, branch target or jump target.
Holds fetched instructions while the decode stage stalls on a hazard. Squashes in-flight fetches on redirect and flags a memory timeout.
Sits between the decode stage (redirect and hazard inputs) and instruction memory. Drives the IF/ID pipeline register inputs.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
MEM_TIMEOUT, 16, cycles a request may stay unacknowledged before the error state; range 1..255.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
hazard  input  1  decode stall; hold current instruction outputs
outputBrachControlInput  input  1  branch taken (redirect)
pcBranchInput  input  32  branch target
jumpInput  input  1  jump (redirect)
pcJumpInput  input  32  jump target
memAckInput  input  1  memory has returned data for the outstanding request
memDataInput  input  32  instruction word, valid with memAckInput
memReqOutput  output  1  request outstanding
memAddrOutput  output  32  fetch address, stable while memReqOutput=1
instructionOutput  output  32  fetched instruction to decode
pc4Output  output  32  fetch address + 4 for that instruction
validOutput  output  1  instructionOutput/pc4Output hold a live instruction
timeoutOutput  output  1  sticky memory-timeout error

Behaviour:
- Reset is asynchronous: state=IDLE, pc=RESET_PC, waitCount=0, squash=0. Outputs: memReqOutput=0, memAddrOutput=RESET_PC, instructionOutput=0, pc4Output=0, validOutput=0, timeoutOutput=0.
- Reset asserted mid-request: state returns to IDLE immediately. A late ack after reset is ignored in IDLE.
- Redirect target = pcBranchInput if the branch input is high, else pcJumpInput if jumpInput is high. Branch wins when both are high.
- Bits [1:0] of every target are forced to 0. PC+4 wraps modulo 2^32.
- FSM states: IDLE, REQ, HOLD, ERROR.
- IDLE: exits to REQ after exactly one cycle.
- REQ: memReqOutput=1 and memAddrOutput=pc. waitCount increments each cycle without ack.
  - Ack, no squash, no redirect this cycle: next cycle instructionOutput=memDataInput, pc4Output=pc+4, validOutput=1, pc=pc+4, waitCount=0.
  - After that ack: if hazard=1, go to HOLD; otherwise stay in REQ and issue the next address with no bubble. Fetch latency is request-to-ack plus 1 register cycle.
  - Redirect while waiting (no ack): squash=1, pc=target. A later redirect overwrites the target; latest wins. memAddrOutput stays at the original address until ack.
  - Ack with squash=1, or ack coincident with a redirect: data discarded, validOutput=0 next cycle, squash cleared, pc=target, next request issued at the target.
  - No ack in a cycle: validOutput=0 next cycle, unless held by hazard.
  - waitCount reaches MEM_TIMEOUT with no ack: go to ERROR.
- HOLD: memReqOutput=0 and all instruction outputs are held unchanged.
  - hazard drops: go to REQ at pc.
  - Redirect: beats hazard. validOutput=0 next cycle, pc=target, go to REQ.
- ERROR: memReqOutput=0, validOutput=0, timeoutOutput=1. Terminal until reset; acks are ignored.
- hazard and redirect inputs are sampled only at clk edges. No combinational path exists from any input to any output.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - fetch_state_t enum {IDLE, REQ, HOLD, ERROR}
  - INSTR_BYTES=4
  - DEFAULT_RESET_PC
  - DEFAULT_MEM_TIMEOUT
- One combinational sub-module, fetch_redirect_select. It takes the branch/jump flags and targets, and outputs a redirect flag and the aligned target.
- The FSM, PC register, squash flag and wait counter live in fetch_controller.

Test Plan:
1. Reset, then ack every cycle with data=addr^32'hA5A5_A5A5, for 4 acks. Required: addresses 0,4,8,C back-to-back; validOutput high from the cycle after the first ack; pc4Output=4,8,C,10.
2. Ack delayed 3 cycles on address 8. Required: memAddrOutput held at 8 for 4 cycles; validOutput low for exactly 3 cycles; then instruction for 8 with pc4Output=C.
3. Hazard=1 for 5 cycles after the ack for address 4. Required: memReqOutput=0; outputs frozen at instr(4)/pc4=8; fetch of 8 starts the cycle after hazard drops.
4. Jump to 32'h100 while the request for C is outstanding, then ack 2 cycles later. Required: data for C discarded (validOutput stays 0); next request at 0x100. Branch to 0x200 in the same cycle as the jump: next request at 0x200.
5. Hold ack low for 16 cycles (MEM_TIMEOUT=16). Required: timeoutOutput=1, memReqOutput=0 and stays 0 through later acks. Asserting reset clears the error, and fetch restarts at RESET_PC.
6. Jump target 32'h103, and separately an ack with pc=FFFF_FFFC. Required: request at 0x100; pc4Output=0 (wrap).

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the FSM encoding, the fetch geometry and the redirect-target alignment helper.
package fetch_ctrl_pkg;

    localparam int unsigned XLEN                = 32;
    localparam int unsigned INSTR_BYTES         = 4;
    localparam int unsigned WAIT_W              = 8;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
    localparam int unsigned DEFAULT_MEM_TIMEOUT = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        HOLD  = ST_HOLD,
        ERROR = ST_ERROR
    } fetch_state_t;

    // Instructions are word aligned; low address bits of any target are dropped.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
        return {t[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_select.sv
// Combinational redirect arbitration: branch beats jump, target forced word aligned.
module fetch_redirect_select
    import fetch_ctrl_pkg::*;
(
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic            redirect_c,
    output logic [XLEN-1:0] target_c
);

    always_comb begin
        redirect_c = branch_taken | jump;
        target_c   = align_target(branch_taken ? branch_target : jump_target);
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, runs the req/ack handshake to instruction
// memory, squashes wrong-path fetches on redirect and holds IF/ID outputs during stalls.
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard,
    input  logic        outputBrachControlInput,
    input  logic [31:0] pcBranchInput,
    input  logic        jumpInput,
    input  logic [31:0] pcJumpInput,
    input  logic        memAckInput,
    input  logic [31:0] memDataInput,
    output logic        memReqOutput,
    output logic [31:0] memAddrOutput,
    output logic [31:0] instructionOutput,
    output logic [31:0] pc4Output,
    output logic        validOutput,
    output logic        timeoutOutput
);

    fetch_state_t      state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic              squash, squash_n;

    logic              mem_req_n;
    logic [XLEN-1:0]   mem_addr_n;
    logic [XLEN-1:0]   instr_n;
    logic [XLEN-1:0]   pc4_n;
    logic              valid_n;
    logic              timeout_n;
    logic              issue;

    logic              redirect;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_plus4;

    fetch_redirect_select u_redirect (
        .branch_taken  (outputBrachControlInput),
        .branch_target (pcBranchInput),
        .jump          (jumpInput),
        .jump_target   (pcJumpInput),
        .redirect_c    (redirect),
        .target_c      (target)
    );

    assign pc_plus4 = pc + XLEN'(INSTR_BYTES);

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        wait_n     = wait_cnt;
        squash_n   = squash;
        mem_addr_n = memAddrOutput;
        instr_n    = instructionOutput;
        pc4_n      = pc4Output;
        valid_n    = validOutput;
        timeout_n  = timeoutOutput;
        issue      = 1'b0;

        case (state)
            IDLE: begin
                state_n = REQ;
                wait_n  = '0;
                issue   = 1'b1;
            end

            REQ: begin
                if (memAckInput) begin
                    wait_n = '0;
                    if (squash || redirect) begin
                        // Wrong-path data is dropped and the next fetch starts at the target.
                        valid_n  = 1'b0;
                        squash_n = 1'b0;
                        if (redirect) begin
                            pc_n = target;
                        end
                        issue = 1'b1;
                    end else begin
                        instr_n = memDataInput;
                        pc4_n   = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                        if (hazard) begin
                            state_n = HOLD;
                        end else begin
                            issue = 1'b1;
                        end
                    end
                end else begin
                    wait_n = WAIT_W'(wait_cnt + 1'b1);
                    if (!hazard || redirect) begin
                        valid_n = 1'b0;
                    end
                    // The request address stays put; only the resume PC moves.
                    if (redirect) begin
                        squash_n = 1'b1;
                        pc_n     = target;
                    end
                    if (wait_n == WAIT_W'(MEM_TIMEOUT)) begin
                        state_n   = ERROR;
                        valid_n   = 1'b0;
                        timeout_n = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    valid_n = 1'b0;
                    pc_n    = target;
                    state_n = REQ;
                    wait_n  = '0;
                    issue   = 1'b1;
                end else if (!hazard) begin
                    state_n = REQ;
                    wait_n  = '0;
                    issue   = 1'b1;
                end
            end

            ERROR: begin
                valid_n   = 1'b0;
                timeout_n = 1'b1;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        mem_req_n = (state_n == REQ);
        if (issue) begin
            mem_addr_n = pc_n;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            pc                <= RESET_PC;
            wait_cnt          <= '0;
            squash            <= 1'b0;
            memReqOutput      <= 1'b0;
            memAddrOutput     <= RESET_PC;
            instructionOutput <= '0;
            pc4Output         <= '0;
            validOutput       <= 1'b0;
            timeoutOutput     <= 1'b0;
        end else begin
            state             <= state_n;
            pc                <= pc_n;
            wait_cnt          <= wait_n;
            squash            <= squash_n;
            memReqOutput      <= mem_req_n;
            memAddrOutput     <= mem_addr_n;
            instructionOutput <= instr_n;
            pc4Output         <= pc4_n;
            validOutput       <= valid_n;
            timeoutOutput     <= timeout_n;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a vector table for steady-state fetch, stalls and
// redirects, followed by hand-written timeout and reset sequences.
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic        hazard;
    logic        br;
    logic [31:0] br_tgt;
    logic        jp;
    logic [31:0] jp_tgt;
    logic        ack;
    logic [31:0] dat;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        tout;

    int checks;
    int errors;

    fetch_controller #(
        .RESET_PC    (32'h0000_0000),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .hazard                  (hazard),
        .outputBrachControlInput (br),
        .pcBranchInput           (br_tgt),
        .jumpInput               (jp),
        .pcJumpInput             (jp_tgt),
        .memAckInput             (ack),
        .memDataInput            (dat),
        .memReqOutput            (req),
        .memAddrOutput           (addr),
        .instructionOutput       (instr),
        .pc4Output               (pc4),
        .validOutput             (valid),
        .timeoutOutput           (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hz;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        ack;
        logic [31:0] dat;
        logic        req;
        logic [31:0] addr;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        vld;
        logic        to;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] d(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic vec_t mk(input logic hz, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt,
                                input logic a, input logic [31:0] dt,
                                input logic rq, input logic [31:0] ad, input logic [31:0] ins,
                                input logic [31:0] p4, input logic vl, input logic to);
        vec_t v;
        v.hz = hz; v.br = b; v.bt = bt; v.jp = j; v.jt = jt; v.ack = a; v.dat = dt;
        v.req = rq; v.addr = ad; v.ins = ins; v.p4 = p4; v.vld = vl; v.to = to;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hz, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt,
                         input logic a, input logic [31:0] dt);
        hazard = hz; br = b; br_tgt = bt; jp = j; jp_tgt = jt; ack = a; dat = dt;
    endtask

    task automatic chk(input string nm, input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_ins, input logic [31:0] e_p4,
                       input logic e_vld, input logic e_to);
        checks++;
        if ({req, addr, instr, pc4, valid, tout} !== {e_req, e_addr, e_ins, e_p4, e_vld, e_to}) begin
            errors++;
            $display("FAIL %s: got req=%0b addr=%h instr=%h pc4=%h valid=%0b timeout=%0b, expected req=%0b addr=%h instr=%h pc4=%h valid=%0b timeout=%0b",
                     nm, req, addr, instr, pc4, valid, tout,
                     e_req, e_addr, e_ins, e_p4, e_vld, e_to);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        // hz br bt jp jt ack dat | req addr instr pc4 valid timeout
        // Back-to-back fetch of 0,4,8,C
        tbl.push_back(mk(0,0,0,0,0, 0,0,               1,32'h0,   32'h0,    32'h0,  0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h0),        1,32'h4,   d(32'h0), 32'h4,  1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h4),        1,32'h8,   d(32'h4), 32'h8,  1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h8),        1,32'hC,   d(32'h8), 32'hC,  1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'hC),        1,32'h10,  d(32'hC), 32'h10, 1,0));
        // Jump back to 8 while 0x10 outstanding; its ack is discarded
        tbl.push_back(mk(0,0,0,1,32'h8, 0,0,           1,32'h10,  d(32'hC), 32'h10, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h10),       1,32'h8,   d(32'hC), 32'h10, 0,0));
        // Ack for 8 delayed by three cycles
        tbl.push_back(mk(0,0,0,0,0, 0,0,               1,32'h8,   d(32'hC), 32'h10, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,               1,32'h8,   d(32'hC), 32'h10, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,               1,32'h8,   d(32'hC), 32'h10, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h8),        1,32'hC,   d(32'h8), 32'hC,  1,0));
        // Hazard for five cycles starting with the ack for C
        tbl.push_back(mk(1,0,0,0,0, 1,d(32'hC),        0,32'hC,   d(32'hC), 32'h10, 1,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,               0,32'hC,   d(32'hC), 32'h10, 1,0));
        tbl.push_back(mk(1,0,0,0,0, 1,32'hDEAD_BEEF,   0,32'hC,   d(32'hC), 32'h10, 1,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,               0,32'hC,   d(32'hC), 32'h10, 1,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,               0,32'hC,   d(32'hC), 32'h10, 1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,               1,32'h10,  d(32'hC), 32'h10, 1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h10),       1,32'h14,  d(32'h10),32'h14, 1,0));
        // Jump to 0x100 while 0x14 outstanding, ack two cycles later
        tbl.push_back(mk(0,0,0,1,32'h100, 0,0,         1,32'h14,  d(32'h10),32'h14, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,               1,32'h14,  d(32'h10),32'h14, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h14),       1,32'h100, d(32'h10),32'h14, 0,0));
        // Branch and jump together: branch wins
        tbl.push_back(mk(0,1,32'h200,1,32'h300, 0,0,   1,32'h100, d(32'h10),32'h14, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h100),      1,32'h200, d(32'h10),32'h14, 0,0));
        // Jump to unaligned 0x103 coincident with an ack
        tbl.push_back(mk(0,0,0,1,32'h103, 1,d(32'h200),1,32'h100, d(32'h10),32'h14, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h100),      1,32'h104, d(32'h100),32'h104,1,0));
        // PC wrap at FFFF_FFFC
        tbl.push_back(mk(0,0,0,1,32'hFFFF_FFFF, 0,0,   1,32'h104, d(32'h100),32'h104,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h104),      1,32'hFFFF_FFFC, d(32'h100),32'h104,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'hFFFF_FFFC),1,32'h0,   d(32'hFFFF_FFFC),32'h0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,               1,32'h0,   d(32'hFFFF_FFFC),32'h0,0,0));
        // Branch alone, then redirect out of HOLD
        tbl.push_back(mk(0,1,32'h42,0,0, 1,d(32'h0),   1,32'h40,  d(32'hFFFF_FFFC),32'h0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h40),       1,32'h44,  d(32'h40), 32'h44, 1,0));
        tbl.push_back(mk(1,0,0,0,0, 1,d(32'h44),       0,32'h44,  d(32'h44), 32'h48, 1,0));
        tbl.push_back(mk(1,0,0,1,32'h80, 0,0,          1,32'h80,  d(32'h44), 32'h48, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,d(32'h80),       1,32'h84,  d(32'h80), 32'h84, 1,0));

        drive(0,0,0,0,0,0,0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 32'h0, 32'h0, 32'h0, 0, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].hz, tbl[i].br, tbl[i].bt, tbl[i].jp, tbl[i].jt, tbl[i].ack, tbl[i].dat);
            step();
            chk($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].ins, tbl[i].p4,
                tbl[i].vld, tbl[i].to);
        end

        // Timeout: 0x84 outstanding, ack held low
        drive(0,0,0,0,0,0,0);
        for (int i = 1; i < 16; i++) begin
            step();
            chk($sformatf("wait%0d", i), 1, 32'h84, d(32'h80), 32'h84, 0, 0);
        end
        step();
        chk("timeout", 0, 32'h84, d(32'h80), 32'h84, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0,0,0,1,32'h500,1,32'h1234_5678);
            step();
            chk($sformatf("err_ack%0d", i), 0, 32'h84, d(32'h80), 32'h84, 0, 1);
        end

        // Asynchronous reset clears the error
        drive(0,0,0,0,0,0,0);
        #2;
        reset = 1'b1;
        #1;
        chk("err_reset", 0, 32'h0, 32'h0, 32'h0, 0, 0);
        step();
        reset = 1'b0;
        step();
        chk("restart_req", 1, 32'h0, 32'h0, 32'h0, 0, 0);
        drive(0,0,0,0,0,1,d(32'h0));
        step();
        chk("restart_ack", 1, 32'h4, d(32'h0), 32'h4, 1, 0);

        // Reset mid-request, then a late ack while in IDLE
        drive(0,0,0,0,0,0,0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset", 0, 32'h0, 32'h0, 32'h0, 0, 0);
        step();
        reset = 1'b0;
        drive(0,0,0,0,0,1,d(32'h4));
        step();
        chk("late_ack", 1, 32'h0, 32'h0, 32'h0, 0, 0);
        drive(0,0,0,0,0,0,0);
        step();
        chk("post_reset_wait", 1, 32'h0, 32'h0, 32'h0, 0, 0);
        drive(0,0,0,0,0,1,d(32'h0));
        step();
        chk("post_reset_ack", 1, 32'h4, d(32'h0), 32'h4, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
